// File: rtl/duck_hunt_pkg.sv
// Shared screen constants and hit_detector state encoding for the duck hunt datapath.
package duck_hunt_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  // Coordinate that disabled sprite drawers emit so their plots land off-screen.
  localparam logic [X_W-1:0] OFFSCREEN_X = {X_W{1'b1}};
  localparam logic [Y_W-1:0] OFFSCREEN_Y = {Y_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SCAN       = 2'd2,
    ST_REPORT     = 2'd3
  } hd_state_e;

endpackage

// File: rtl/hit_detector_if.sv
// Pixel plot bus, shot trigger and result signals seen by hit_detector.
interface hit_detector_if
  import duck_hunt_pkg::*;
#(
  parameter int SCORE_W = 8
) ();

  logic               frame_tick;
  logic               shot;
  logic [X_W-1:0]     shot_x;
  logic [Y_W-1:0]     shot_y;
  logic               pix_valid;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic               pix_erase;
  logic               score_clr;
  logic               busy;
  logic               hit;
  logic               miss;
  logic [SCORE_W-1:0] score;

  modport master (
    output frame_tick, shot, shot_x, shot_y,
    output pix_valid, pix_x, pix_y, pix_erase, score_clr,
    input  busy, hit, miss, score
  );

  modport slave (
    input  frame_tick, shot, shot_x, shot_y,
    input  pix_valid, pix_x, pix_y, pix_erase, score_clr,
    output busy, hit, miss, score
  );

endinterface

// File: rtl/hit_detector_coord_window.sv
// Per-axis proximity test: is the unsigned distance between two coordinates within radius.
module coord_window #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] radius_i,
  output logic         within_o
);

  logic [W:0] diff_s;

  // Distance taken as max-min so screen edges never wrap into each other.
  always_comb begin
    diff_s = {(W+1){1'b0}};
    if (a_i >= b_i) begin
      diff_s = {1'b0, a_i} - {1'b0, b_i};
    end else begin
      diff_s = {1'b0, b_i} - {1'b0, a_i};
    end
    within_o = (diff_s <= {1'b0, radius_i});
  end

endmodule

// File: rtl/hit_detector.sv
// Latches a shot, scans the next full frame of bird pixels for a match, and
// reports one hit or miss per shot while keeping a saturating score.
module hit_detector
  import duck_hunt_pkg::*;
#(
  parameter int HIT_RADIUS = 1,
  parameter int SCORE_W    = 8
) (
  input  logic          clock,
  input  logic          resetn,
  hit_detector_if.slave bus
);

  localparam logic [X_W-1:0]     RAD_X     = X_W'(HIT_RADIUS);
  localparam logic [Y_W-1:0]     RAD_Y     = Y_W'(HIT_RADIUS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  hd_state_e          state_q, state_d;
  logic [X_W-1:0]     shot_x_q, shot_x_d;
  logic [Y_W-1:0]     shot_y_q, shot_y_d;
  logic               busy_q, busy_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic               win_x_s;
  logic               win_y_s;
  logic               cand_s;
  logic               match_s;

  coord_window #(.W(X_W)) u_win_x (
    .a_i      (bus.pix_x),
    .b_i      (shot_x_q),
    .radius_i (RAD_X),
    .within_o (win_x_s)
  );

  coord_window #(.W(Y_W)) u_win_y (
    .a_i      (bus.pix_y),
    .b_i      (shot_y_q),
    .radius_i (RAD_Y),
    .within_o (win_y_s)
  );

  // Erase passes and parked (off-screen) sprites never count as birds.
  assign cand_s  = bus.pix_valid && !bus.pix_erase &&
                   (bus.pix_x != OFFSCREEN_X) && (bus.pix_y != OFFSCREEN_Y);
  assign match_s = cand_s && win_x_s && win_y_s;

  // Next-state, shot latch and result pulse decode.
  always_comb begin
    state_d  = state_q;
    shot_x_d = shot_x_q;
    shot_y_d = shot_y_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.shot) begin
          shot_x_d = bus.shot_x;
          shot_y_d = bus.shot_y;
          state_d  = ST_WAIT_FRAME;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_FRAME: begin
        if (bus.frame_tick) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_SCAN: begin
        if (match_s) begin
          hit_d   = 1'b1;
          state_d = ST_REPORT;
        end else if (bus.frame_tick) begin
          miss_d  = 1'b1;
          state_d = ST_REPORT;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Score update: hit_q is high only during a REPORT that carries a hit.
  always_comb begin
    score_d = score_q;
    if (bus.score_clr) begin
      score_d = {SCORE_W{1'b0}};
    end else if ((state_q == ST_REPORT) && hit_q && (score_q != SCORE_MAX)) begin
      score_d = score_q + SCORE_ONE;
    end else begin
      score_d = score_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      shot_x_q <= {X_W{1'b0}};
      shot_y_q <= {Y_W{1'b0}};
      busy_q   <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      score_q  <= {SCORE_W{1'b0}};
    end else begin
      state_q  <= state_d;
      shot_x_q <= shot_x_d;
      shot_y_q <= shot_y_d;
      busy_q   <= busy_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      score_q  <= score_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.hit   = hit_q;
  assign bus.miss  = miss_q;
  assign bus.score = score_q;

endmodule

// File: tb/tb_hit_detector.sv
// Directed bench for hit_detector: hit, miss, filtering, busy shots, saturation, reset.
module tb_hit_detector;

  logic clock;
  logic resetn;
  int   checks;
  int   errors;
  int   exp_score;

  hit_detector_if #(.SCORE_W(8)) bus ();

  hit_detector #(.HIT_RADIUS(1), .SCORE_W(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    bus.frame_tick = 1'b0;
    bus.shot       = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_erase  = 1'b0;
    bus.score_clr  = 1'b0;
  endtask

  task automatic fire(input logic [7:0] x, input logic [6:0] y);
    bus.shot = 1'b1; bus.shot_x = x; bus.shot_y = y;
    step();
    bus.shot = 1'b0;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic erase);
    bus.pix_valid = 1'b1; bus.pix_x = x; bus.pix_y = y; bus.pix_erase = erase;
    step();
    bus.pix_valid = 1'b0; bus.pix_erase = 1'b0;
  endtask

  task automatic quick_hit();
    fire(8'd20, 7'd20);
    tick();
    plot(8'd20, 7'd20, 1'b0);
    step();
  endtask

  initial begin
    checks = 0; errors = 0; exp_score = 0;
    idle_bus();
    bus.shot_x = 8'd0; bus.shot_y = 7'd0; bus.pix_x = 8'd0; bus.pix_y = 7'd0;
    resetn = 1'b0;
    step(); step();
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_hit", {31'd0, bus.hit}, 32'd0);
    check_eq("rst_miss", {31'd0, bus.miss}, 32'd0);
    check_eq("rst_score", {24'd0, bus.score}, 32'd0);
    resetn = 1'b1;
    step();

    // Hit at distance (1,1)
    fire(8'd80, 7'd60);
    check_eq("t1_busy_up", {31'd0, bus.busy}, 32'd1);
    tick();
    plot(8'd81, 7'd59, 1'b0);
    check_eq("t1_hit", {31'd0, bus.hit}, 32'd1);
    check_eq("t1_miss", {31'd0, bus.miss}, 32'd0);
    step();
    exp_score = 1;
    check_eq("t1_hit_low", {31'd0, bus.hit}, 32'd0);
    check_eq("t1_score", {24'd0, bus.score}, exp_score);
    check_eq("t1_busy_down", {31'd0, bus.busy}, 32'd0);

    // Near-miss pixels, then frame ends
    fire(8'd80, 7'd60);
    tick();
    plot(8'd83, 7'd60, 1'b0);
    check_eq("t2_hit_a", {31'd0, bus.hit}, 32'd0);
    plot(8'd80, 7'd63, 1'b0);
    check_eq("t2_hit_b", {31'd0, bus.hit}, 32'd0);
    tick();
    check_eq("t2_miss", {31'd0, bus.miss}, 32'd1);
    check_eq("t2_hit_c", {31'd0, bus.hit}, 32'd0);
    step();
    check_eq("t2_score", {24'd0, bus.score}, exp_score);
    check_eq("t2_busy", {31'd0, bus.busy}, 32'd0);

    // Erase pixel and off-screen code are ignored
    fire(8'd10, 7'd10);
    tick();
    plot(8'd10, 7'd10, 1'b1);
    check_eq("t3_erase", {31'd0, bus.hit}, 32'd0);
    plot(8'd255, 7'd127, 1'b0);
    check_eq("t3_offscr", {31'd0, bus.hit}, 32'd0);
    tick();
    check_eq("t3_miss", {31'd0, bus.miss}, 32'd1);
    step();

    // Off-screen code on one axis only, and no wrap across screen edge
    fire(8'd254, 7'd126);
    tick();
    plot(8'd255, 7'd126, 1'b0);
    check_eq("t3b_offx", {31'd0, bus.hit}, 32'd0);
    plot(8'd254, 7'd127, 1'b0);
    check_eq("t3b_offy", {31'd0, bus.hit}, 32'd0);
    plot(8'd0, 7'd126, 1'b0);
    check_eq("t3b_nowrap", {31'd0, bus.hit}, 32'd0);
    tick();
    check_eq("t3b_miss", {31'd0, bus.miss}, 32'd1);
    step();

    // Shot during SCAN is ignored
    fire(8'd50, 7'd50);
    tick();
    fire(8'd0, 7'd0);
    plot(8'd0, 7'd0, 1'b0);
    check_eq("t4_noover", {31'd0, bus.hit}, 32'd0);
    plot(8'd50, 7'd50, 1'b0);
    check_eq("t4_hit", {31'd0, bus.hit}, 32'd1);
    step();
    exp_score = 2;
    check_eq("t4_score", {24'd0, bus.score}, exp_score);
    step();
    check_eq("t4_idle", {31'd0, bus.busy}, 32'd0);

    // shot+tick together, tick-cycle pixels skipped, hit beats tick
    bus.frame_tick = 1'b1;
    fire(8'd30, 7'd30);
    bus.frame_tick = 1'b0;
    plot(8'd30, 7'd30, 1'b0);
    check_eq("t5_wait_hit", {31'd0, bus.hit}, 32'd0);
    bus.frame_tick = 1'b1;
    plot(8'd30, 7'd30, 1'b0);
    bus.frame_tick = 1'b0;
    check_eq("t5_tickcyc", {31'd0, bus.hit}, 32'd0);
    bus.frame_tick = 1'b1;
    plot(8'd31, 7'd31, 1'b0);
    bus.frame_tick = 1'b0;
    check_eq("t5_hitwins", {31'd0, bus.hit}, 32'd1);
    check_eq("t5_nomiss", {31'd0, bus.miss}, 32'd0);
    step();
    exp_score = 3;
    check_eq("t5_score", {24'd0, bus.score}, exp_score);

    // Saturation at 255
    for (int i = 0; i < 252; i++) begin
      quick_hit();
    end
    check_eq("t6_score255", {24'd0, bus.score}, 32'd255);
    quick_hit();
    check_eq("t6_sat", {24'd0, bus.score}, 32'd255);
    fire(8'd40, 7'd40);
    tick();
    plot(8'd40, 7'd40, 1'b0);
    check_eq("t6_hit", {31'd0, bus.hit}, 32'd1);
    bus.score_clr = 1'b1;
    step();
    bus.score_clr = 1'b0;
    check_eq("t6_clr_wins", {24'd0, bus.score}, 32'd0);

    // Async reset during SCAN
    quick_hit();
    check_eq("t7_pre", {24'd0, bus.score}, 32'd1);
    fire(8'd70, 7'd70);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check_eq("t7_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("t7_score", {24'd0, bus.score}, 32'd0);
    step();
    resetn = 1'b1;
    step();
    plot(8'd70, 7'd70, 1'b0);
    check_eq("t7_nohit", {31'd0, bus.hit}, 32'd0);
    tick();
    check_eq("t7_nomiss", {31'd0, bus.miss}, 32'd0);
    check_eq("t7_idle", {31'd0, bus.busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
